matrix_feeder: RTL

MATRIX_FEEDER -- requirements
Module: matrix_feeder

---
 rtl/matrix_feeder.sv | 109 ++++++++++
 1 files changed

// File: rtl/matrix_feeder.sv
// Streams one vector A (COLUMN_SIZE beats) followed by one matrix B (COLUMN_SIZE*ROW_SIZE beats)
// into wide operand registers and holds them for a downstream multiplier until it acknowledges.
module matrix_feeder #(
  parameter int DATA_SIZE   = 8,
  parameter int COLUMN_SIZE = 64,
  parameter int ROW_SIZE    = 64
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DATA_SIZE-1:0]                     in_data,
  input  logic                                     in_last,
  input  logic                                     flush,
  input  logic                                     mat_ack,
  output logic [DATA_SIZE*COLUMN_SIZE-1:0]          datsA,
  output logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0] datsB,
  output logic                                     mat_valid,
  output logic                                     frame_err
);

  localparam int B_BEATS = COLUMN_SIZE * ROW_SIZE;
  localparam int IDX_W   = (B_BEATS > 1) ? $clog2(B_BEATS) : 1;
  localparam logic [IDX_W-1:0] A_LAST = IDX_W'(COLUMN_SIZE - 1);
  localparam logic [IDX_W-1:0] B_LAST = IDX_W'(B_BEATS - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             accept;

  // Ready also depends on reset so that it drops the instant reset is asserted.
  assign in_ready = reset && !flush && (state != FULL);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= LOAD_A;
      idx       <= '0;
      datsA     <= '0;
      datsB     <= '0;
      mat_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (flush) begin
        state     <= LOAD_A;
        idx       <= '0;
        mat_valid <= 1'b0;
      end else begin
        case (state)
          LOAD_A: begin
            if (accept) begin
              // Only the very last beat of the B phase may carry in_last.
              if (in_last) begin
                frame_err <= 1'b1;
                idx       <= '0;
              end else begin
                datsA[idx*DATA_SIZE +: DATA_SIZE] <= in_data;
                if (idx == A_LAST) begin
                  state <= LOAD_B;
                  idx   <= '0;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end
          end
          LOAD_B: begin
            if (accept) begin
              if (in_last != (idx == B_LAST)) begin
                frame_err <= 1'b1;
                state     <= LOAD_A;
                idx       <= '0;
              end else begin
                datsB[idx*DATA_SIZE +: DATA_SIZE] <= in_data;
                if (idx == B_LAST) begin
                  state     <= FULL;
                  mat_valid <= 1'b1;
                  idx       <= '0;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end
          end
          FULL: begin
            if (mat_ack) begin
              state     <= LOAD_A;
              mat_valid <= 1'b0;
              idx       <= '0;
            end
          end
          default: begin
            state     <= LOAD_A;
            idx       <= '0;
            mat_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
